// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: word FIFO feeding a double-buffered weight register file.
// Rev 1.0 - shadow bank loads row-major from the FIFO, SWAP makes it active.
`default_nettype none

module weight_load_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_R      = 5,
  parameter int MAX_S      = 5
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          CLEAR_FIFO,
  input  logic                          LOAD_WS,
  input  logic                          SWAP,
  input  logic                          FIFO_WR_CMD,
  input  logic [DATA_WIDTH-1:0]         FIFO_WR_DATA,
  output logic                          FIFO_EMPTY,
  output logic                          FIFO_FULL,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  input  logic [3:0]                    PARAM_R,
  input  logic [3:0]                    PARAM_S,
  output logic                          LOAD_BUSY,
  output logic                          LOAD_DONE,
  output logic                          PARAM_ERR,
  output logic                          ACTIVE_BANK,
  input  logic [3:0]                    WS_RD_ROW,
  output logic [MAX_S*DATA_WIDTH-1:0]   WS_RD_DATA
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] MAX_R4 = 4'(MAX_R);
  localparam logic [3:0] MAX_S4 = 4'(MAX_S);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic [DATA_WIDTH-1:0] bank [2][MAX_R][MAX_S];

  logic [1:0] state;
  logic [3:0] r_len, s_len, row_cnt, col_cnt;
  logic       clear_q, load_q, param_err, active_bank;

  logic clear_edge, load_edge, push, pop, params_ok, last_elem, start_ok, shadow_sel;

  assign clear_edge = CLEAR_FIFO & ~clear_q;
  assign load_edge  = LOAD_WS & ~load_q;
  assign FIFO_FULL  = (count == (AW+1)'(FIFO_DEPTH));
  assign FIFO_EMPTY = (count == '0);
  assign push       = FIFO_WR_CMD & ~FIFO_FULL;
  // A flush on the same edge takes precedence, so no word is consumed then.
  assign pop        = (state == S_LOAD) & ~FIFO_EMPTY & ~clear_edge;
  assign params_ok  = (PARAM_R != 4'd0) && (PARAM_R <= MAX_R4) &&
                      (PARAM_S != 4'd0) && (PARAM_S <= MAX_S4);
  assign start_ok   = (state == S_IDLE) & load_edge & params_ok;
  assign last_elem  = (row_cnt == r_len - 4'd1) && (col_cnt == s_len - 4'd1);
  assign shadow_sel = ~active_bank;

  assign FIFO_COUNT  = count;
  assign LOAD_BUSY   = (state == S_LOAD);
  assign LOAD_DONE   = (state == S_FULL);
  assign PARAM_ERR   = param_err;
  assign ACTIVE_BANK = active_bank;

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= FIFO_WR_DATA;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_edge) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      r_len       <= '0;
      s_len       <= '0;
      row_cnt     <= '0;
      col_cnt     <= '0;
      param_err   <= 1'b0;
      active_bank <= 1'b0;
      clear_q     <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      clear_q <= CLEAR_FIFO;
      load_q  <= LOAD_WS;
      case (state)
        S_IDLE: begin
          if (load_edge) begin
            if (params_ok) begin
              r_len     <= PARAM_R;
              s_len     <= PARAM_S;
              row_cnt   <= '0;
              col_cnt   <= '0;
              param_err <= 1'b0;
              state     <= S_LOAD;
            end else begin
              param_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (clear_edge) begin
            state <= S_IDLE;
          end else if (pop) begin
            if (last_elem) state <= S_FULL;
            if (col_cnt == s_len - 4'd1) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 4'd1;
            end else begin
              col_cnt <= col_cnt + 4'd1;
            end
          end
        end
        S_FULL: begin
          if (SWAP) begin
            active_bank <= ~active_bank;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Zeroing the shadow at load start makes elements outside R x S read as zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < MAX_R; i++)
          for (int j = 0; j < MAX_S; j++)
            bank[b][i][j] <= '0;
    end else if (start_ok) begin
      for (int i = 0; i < MAX_R; i++)
        for (int j = 0; j < MAX_S; j++)
          bank[shadow_sel][i][j] <= '0;
    end else if (pop) begin
      for (int i = 0; i < MAX_R; i++)
        for (int j = 0; j < MAX_S; j++)
          if (row_cnt == 4'(i) && col_cnt == 4'(j))
            bank[shadow_sel][i][j] <= fifo_mem[rd_ptr];
    end
  end

  always_comb begin
    WS_RD_DATA = '0;
    for (int i = 0; i < MAX_R; i++)
      if (WS_RD_ROW == 4'(i))
        for (int j = 0; j < MAX_S; j++)
          WS_RD_DATA[j*DATA_WIDTH +: DATA_WIDTH] = bank[active_bank][i][j];
  end

endmodule

`default_nettype wire

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: directed scenario tasks with hand-computed expectations.
`default_nettype none

module tb_weight_load_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int MR = 5;
  localparam int MS = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_fifo = 1'b0, load_ws = 1'b0, swap = 1'b0, wr_cmd = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0] param_r = '0, param_s = '0, rd_row = '0;
  logic fifo_empty, fifo_full, load_busy, load_done, param_err, active_bank;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [MS*DW-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  weight_load_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_R(MR), .MAX_S(MS)) dut (
    .CLK(clk), .RESET(rst), .CLEAR_FIFO(clear_fifo), .LOAD_WS(load_ws), .SWAP(swap),
    .FIFO_WR_CMD(wr_cmd), .FIFO_WR_DATA(wr_data), .FIFO_EMPTY(fifo_empty),
    .FIFO_FULL(fifo_full), .FIFO_COUNT(fifo_count), .PARAM_R(param_r), .PARAM_S(param_s),
    .LOAD_BUSY(load_busy), .LOAD_DONE(load_done), .PARAM_ERR(param_err),
    .ACTIVE_BANK(active_bank), .WS_RD_ROW(rd_row), .WS_RD_DATA(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    wr_cmd = 1'b1; wr_data = w;
    tick();
    wr_cmd = 1'b0;
  endtask

  task automatic start_load(input logic [3:0] r, input logic [3:0] s);
    param_r = r; param_s = s; load_ws = 1'b1;
    tick();
    load_ws = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", fifo_full); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    checks++; if ({load_busy, load_done, param_err, active_bank} !== 4'b0000) begin errors++; $display("FAIL rst_status: got %b want 0000", {load_busy, load_done, param_err, active_bank}); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL rst_rd: got %h want 0", rd_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    int busy_cycles;
    int guard;
    for (int i = 1; i <= 9; i++) push_word(DW'(i));
    checks++; if (fifo_count !== 5'd9) begin errors++; $display("FAIL basic_count: got %0d want 9", fifo_count); end
    start_load(4'd3, 4'd3);
    busy_cycles = 0; guard = 0;
    while (load_busy === 1'b1 && guard < 40) begin busy_cycles++; guard++; tick(); end
    checks++; if (busy_cycles !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 9", busy_cycles); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", load_done); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL basic_drain: got %0d want 0", fifo_count); end
    rd_row = 4'd0; #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL basic_active_untouched: got %h want 0", rd_data); end
    do_swap();
    checks++; if ({active_bank, load_done} !== 2'b10) begin errors++; $display("FAIL basic_swap: got %b want 10", {active_bank, load_done}); end
    rd_row = 4'd0; #1;
    checks++; if (rd_data !== {32'd0, 32'd0, 32'd3, 32'd2, 32'd1}) begin errors++; $display("FAIL basic_row0: got %h want 3,2,1", rd_data); end
    rd_row = 4'd2; #1;
    checks++; if (rd_data !== {32'd0, 32'd0, 32'd9, 32'd8, 32'd7}) begin errors++; $display("FAIL basic_row2: got %h want 9,8,7", rd_data); end
    rd_row = 4'd3; #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL basic_row3: got %h want 0", rd_data); end
    rd_row = 4'd7; #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL basic_row_oob: got %h want 0", rd_data); end
    do_swap();
    checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL swap_in_idle: got %b want 1", active_bank); end
  endtask

  task automatic test_stall();
    start_load(4'd2, 4'd2);
    checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL stall_start: got %b want 1", load_busy); end
    for (int k = 0; k < 4; k++) begin
      tick(); tick();
      checks++; if (load_busy !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL stall_wait%0d: got busy %b done %b want 1 0", k, load_busy, load_done); end
      push_word(DW'(10 * (k + 1)));
    end
    checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL stall_no_fallthrough: got %b want 1", load_busy); end
    tick();
    checks++; if ({load_done, fifo_count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL stall_done: got done %b count %0d want 1 0", load_done, fifo_count); end
    do_swap();
    rd_row = 4'd0; #1;
    checks++; if (rd_data !== {32'd0, 32'd0, 32'd0, 32'd20, 32'd10}) begin errors++; $display("FAIL stall_row0: got %h want 20,10", rd_data); end
    rd_row = 4'd1; #1;
    checks++; if (rd_data !== {32'd0, 32'd0, 32'd0, 32'd40, 32'd30}) begin errors++; $display("FAIL stall_row1: got %h want 40,30", rd_data); end
    rd_row = 4'd2; #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL stall_row2: got %h want 0", rd_data); end
  endtask

  task automatic test_param_err();
    push_word(32'd77);
    start_load(4'd6, 4'd2);
    checks++; if ({param_err, load_busy} !== 2'b10) begin errors++; $display("FAIL perr_set: got %b want 10", {param_err, load_busy}); end
    tick();
    checks++; if ({param_err, fifo_count} !== {1'b1, 5'd1}) begin errors++; $display("FAIL perr_nopop: got err %b count %0d want 1 1", param_err, fifo_count); end
    start_load(4'd1, 4'd1);
    checks++; if ({param_err, load_busy} !== 2'b01) begin errors++; $display("FAIL perr_clear: got %b want 01", {param_err, load_busy}); end
    tick();
    checks++; if ({load_done, fifo_count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL perr_load: got done %b count %0d want 1 0", load_done, fifo_count); end
    start_load(4'd3, 4'd3);
    checks++; if ({load_done, load_busy} !== 2'b10) begin errors++; $display("FAIL load_in_full: got %b want 10", {load_done, load_busy}); end
    do_swap();
    rd_row = 4'd0; #1;
    checks++; if ({active_bank, rd_data} !== {1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd77}) begin errors++; $display("FAIL perr_row0: got bank %b data %h want 1 77", active_bank, rd_data); end
    rd_row = 4'd1; #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL perr_zeroed: got %h want 0", rd_data); end
  endtask

  task automatic test_fifo_full();
    int guard;
    for (int i = 0; i < 16; i++) push_word(DW'(100 + i));
    checks++; if ({fifo_full, fifo_count} !== {1'b1, 5'd16}) begin errors++; $display("FAIL full_fill: got full %b count %0d want 1 16", fifo_full, fifo_count); end
    start_load(4'd3, 4'd3);
    push_word(32'd999);
    checks++; if ({fifo_full, fifo_count} !== {1'b0, 5'd15}) begin errors++; $display("FAIL full_drop: got full %b count %0d want 0 15", fifo_full, fifo_count); end
    guard = 0;
    while (load_busy === 1'b1 && guard < 40) begin guard++; tick(); end
    checks++; if ({load_done, fifo_count} !== {1'b1, 5'd7}) begin errors++; $display("FAIL full_after: got done %b count %0d want 1 7", load_done, fifo_count); end
    do_swap();
    rd_row = 4'd2; #1;
    checks++; if ({active_bank, rd_data} !== {1'b0, 32'd0, 32'd0, 32'd108, 32'd107, 32'd106}) begin errors++; $display("FAIL full_row2: got bank %b data %h", active_bank, rd_data); end
  endtask

  task automatic test_clear();
    push_word(32'd200);
    push_word(32'd201);
    start_load(4'd3, 4'd3);
    repeat (4) tick();
    checks++; if ({load_busy, fifo_count} !== {1'b1, 5'd5}) begin errors++; $display("FAIL clr_pre: got busy %b count %0d want 1 5", load_busy, fifo_count); end
    clear_fifo = 1'b1;
    tick();
    checks++; if ({fifo_empty, fifo_count, load_busy, load_done} !== {1'b1, 5'd0, 2'b00}) begin errors++; $display("FAIL clr_abort: got empty %b count %0d busy %b done %b", fifo_empty, fifo_count, load_busy, load_done); end
    rd_row = 4'd0; #1;
    checks++; if ({active_bank, rd_data} !== {1'b0, 32'd0, 32'd0, 32'd102, 32'd101, 32'd100}) begin errors++; $display("FAIL clr_active: got bank %b data %h", active_bank, rd_data); end
    tick();
    clear_fifo = 1'b0;
    tick();
    wr_cmd = 1'b1; wr_data = 32'd5; clear_fifo = 1'b1;
    tick();
    wr_cmd = 1'b0; clear_fifo = 1'b0;
    checks++; if ({fifo_empty, fifo_count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL clr_wins: got empty %b count %0d want 1 0", fifo_empty, fifo_count); end
    tick();
  endtask

  task automatic test_reset_midload();
    push_word(32'd55);
    start_load(4'd1, 4'd1);
    tick();
    do_swap();
    push_word(32'd1); push_word(32'd2); push_word(32'd3);
    start_load(4'd2, 4'd2);
    tick();
    rd_row = 4'd0;
    checks++; if ({active_bank, load_busy, fifo_count} !== {2'b11, 5'd2}) begin errors++; $display("FAIL rmid_pre: got bank %b busy %b count %0d", active_bank, load_busy, fifo_count); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({fifo_empty, fifo_full, fifo_count} !== {2'b10, 5'd0}) begin errors++; $display("FAIL rmid_fifo: got %b %b %0d want 1 0 0", fifo_empty, fifo_full, fifo_count); end
    checks++; if ({load_busy, load_done, param_err, active_bank} !== 4'b0000) begin errors++; $display("FAIL rmid_status: got %b want 0000", {load_busy, load_done, param_err, active_bank}); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL rmid_rd: got %h want 0", rd_data); end
    #1 rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_stall();
    test_param_err();
    test_fifo_full();
    test_clear();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
